// File: rtl/alu_pkg.sv
// Shared constants, opcode codes and FSM state type for the ALU sequencer.
// ALU_SEQ_MUL_EN adds the shift-add multiply opcode to the legal command set.
package alu_pkg;

  localparam int BITS = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_SLT = 3'b101;
  localparam op_t OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Codes the single-pass ALU understands directly.
  function automatic logic is_alu_op(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic is_legal_op(input op_t op);
    logic ok;
    ok = is_alu_op(op);
`ifdef ALU_SEQ_MUL_EN
    ok = ok || (op == OP_MUL);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response bus of the ALU sequencer.
// A transfer happens on a rising edge where valid and ready are both 1; once
// raised, rsp_valid and rsp_data/zero/err stay stable until rsp_ready is seen.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  op_t             cmd_op;
  logic [BITS-1:0] cmd_a;
  logic [BITS-1:0] cmd_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic            rsp_zero;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_8b.sv
// Combinational 8-bit ALU: wrapping ADD/SUB, AND, OR and unsigned SLT.
module alu_8b
  import alu_pkg::*;
(
  input  op_t             op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SLT:  y = {{(BITS-1){1'b0}}, (a < b)};
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer around one alu_8b; EXEC takes one edge, MUL (when
// ALU_SEQ_MUL_EN is defined) runs eight shift-add passes through the same ALU.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus,
  output logic           busy,
  output state_t         state_dbg
);

  state_t          state, state_nxt;
  op_t             op_q;
  logic [BITS-1:0] a_q, b_q;
  logic            err_q;
  logic [BITS-1:0] rsp_data_q;
  logic            rsp_zero_q, rsp_err_q;

  op_t             alu_op;
  logic [BITS-1:0] alu_a, alu_b, alu_y;
  logic            accept;

`ifdef ALU_SEQ_MUL_EN
  logic [2:0]      cnt;
  logic [BITS-1:0] acc;
`endif

  assign accept = (state == ST_IDLE) && bus.cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
`ifdef ALU_SEQ_MUL_EN
          state_nxt = (bus.cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_nxt = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_nxt = ST_DONE;
      ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (cnt == 3'd7) state_nxt = ST_DONE;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_DONE);
    busy          = (state != ST_IDLE);
    state_dbg     = state;
  end

  // Multiply reuses the ALU add path: acc + (a << i) gated by b[i].
  always_comb begin
    alu_op = is_alu_op(op_q) ? op_q : OP_ADD;
    alu_a  = a_q;
    alu_b  = b_q;
`ifdef ALU_SEQ_MUL_EN
    if (state == ST_MUL) begin
      alu_op = OP_ADD;
      alu_a  = acc;
      alu_b  = b_q[cnt] ? (a_q << cnt) : '0;
    end
`endif
  end

  alu_8b u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt        <= '0;
      acc        <= '0;
`endif
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        a_q   <= bus.cmd_a;
        b_q   <= bus.cmd_b;
        err_q <= !is_legal_op(bus.cmd_op);
`ifdef ALU_SEQ_MUL_EN
        cnt   <= '0;
        acc   <= '0;
`endif
      end
      if (state == ST_EXEC) begin
        rsp_data_q <= err_q ? '0 : alu_y;
        rsp_zero_q <= !err_q && (alu_y == '0);
        rsp_err_q  <= err_q;
      end
`ifdef ALU_SEQ_MUL_EN
      if (state == ST_MUL) begin
        acc <= alu_y;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          rsp_data_q <= alu_y;
          rsp_zero_q <= (alu_y == '0);
          rsp_err_q  <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_zero = rsp_zero_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; MUL vectors are built only
// when ALU_SEQ_MUL_EN is defined, otherwise 110 is checked as illegal.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic   clk;
  logic   rst;
  logic   busy;
  state_t state_dbg;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [BITS-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
  endtask

  // Issue one command and scrub the inputs right after the accept edge.
  task automatic issue(input op_t op, input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_SUB;
    bus.cmd_a     = ~a;
    bus.cmd_b     = ~b;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input op_t op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_data,
                         input logic exp_zero, input logic exp_err, input int exp_lat);
    int lat;
    logic [BITS-1:0] e;
    exp_q.push_back(exp_data);
    issue(op, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_data"}, bus.rsp_data, e);
    check({tag, "_zero"}, bus.rsp_zero, exp_zero);
    check({tag, "_err"}, bus.rsp_err, exp_err);
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, "_rdy_in_done"}, bus.cmd_ready, 1'b0);
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_idle_after"}, {busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
  endtask

  // Assert reset mid-cycle and confirm nothing comes back afterwards.
  task automatic reset_and_watch(input string tag);
    int seen;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_rst_data"}, bus.rsp_data, 8'h00);
    check({tag, "_rst_flags"}, {bus.rsp_zero, bus.rsp_err}, 2'b00);
    check({tag, "_rst_ctl"}, {busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
    check({tag, "_rst_state"}, state_dbg, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp_valid || busy) seen++;
    end
    check({tag, "_no_rsp"}, seen, 0);
  endtask

  initial begin
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_ctl", {busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
    check("reset_data", bus.rsp_data, 8'h00);
    check("reset_flags", {bus.rsp_zero, bus.rsp_err}, 2'b00);
    check("reset_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_vec("add_wrap",  OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1);
    run_vec("sub_zero",  OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1);
    run_vec("slt_true",  OP_SLT, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    run_vec("slt_false", OP_SLT, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1);
    run_vec("sub_wrap",  OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1);
    run_vec("and",       OP_AND, 8'hCC, 8'h0F, 8'h0C, 1'b0, 1'b0, 1);
    run_vec("or",        OP_OR,  8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1);
    run_vec("ill_111",   3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1);
    run_vec("ill_100",   3'b100, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
    run_vec("mul_0d_0b", OP_MUL, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8);
    run_vec("mul_10_10", OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 8);
    run_vec("mul_ff_01", OP_MUL, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 8);
`else
    run_vec("ill_110",   OP_MUL, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b1, 1);
`endif

    // Backpressure: hold the response 5 cycles while pulsing cmd_valid.
    issue(OP_ADD, 8'h5A, 8'h11);
    wait_rsp(lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_OR;
      bus.cmd_a     = 8'hFF;
      tick();
      bus.cmd_valid = 1'b0;
      check("bp_valid", bus.rsp_valid, 1'b1);
      check("bp_data", bus.rsp_data, 8'h6B);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    check("bp_no_queue", {busy, bus.rsp_valid}, 2'b00);

`ifdef ALU_SEQ_MUL_EN
    // Reset during iteration 4 of a multiply.
    issue(OP_MUL, 8'hFF, 8'hFF);
    repeat (3) tick();
    reset_and_watch("mul_rst");
`else
    // Reset while a response is waiting in DONE.
    issue(OP_SUB, 8'h80, 8'h01);
    wait_rsp(lat);
    check("done_rst_pre", bus.rsp_data, 8'h7F);
    reset_and_watch("done_rst");
`endif

    run_vec("post_rst_add", OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; datapath width is the shared constant BITS = 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  requester presents a command.
REQ-005 cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
REQ-006 cmd_op  input  3  opcode: ADD 000, SUB 001, AND 010, OR 011, SLT 101, MUL 110.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 rsp_valid  output  1  result held valid; high only in DONE.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_data  output  8  registered result.
REQ-012 rsp_zero  output  1  registered flag, 1 when rsp_data == 0 and rsp_err == 0.
REQ-013 rsp_err  output  1  registered flag, 1 for an illegal or disabled opcode.
REQ-014 busy  output  1  1 in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, MUL, DONE; encoding is free.
REQ-016 Accept happens on the edge where state == IDLE and cmd_valid == 1; opcode and operands are registered at that edge, and later input changes have no effect.
REQ-017 On accept, legal single-pass ops (ADD/SUB/AND/OR/SLT) go to EXEC; MUL goes to MUL; illegal ops go to EXEC with an error marker.
REQ-018 EXEC: the internal ALU computes from the registered operands; on the next edge rsp_data, rsp_zero and rsp_err are captured, and state goes to DONE (rsp_valid is high 1 edge after accept).
REQ-019 Arithmetic: ADD and SUB wrap modulo 256 with no carry or overflow output; SLT is unsigned, giving 8'h01 or 8'h00.
REQ-020 The ALU opcode input is never driven with an undefined code; for illegal ops it is driven with ADD, and rsp_data is forced to 8'h00, rsp_err to 1, rsp_zero to 0.
REQ-021 MUL is shift-add over exactly 8 iterations using the ALU ADD path.
  - Accumulator is cleared at accept.
  - Iteration i (0..7): if b[i] == 1, acc = acc + (a << i) truncated to 8 bits.
  - A 3-bit counter increments each edge.
  - After iteration 7, state goes to DONE, so rsp_valid is high 8 edges after accept.
  - rsp_data is the low 8 bits of a*b, and rsp_zero = (rsp_data == 0).
REQ-022 DONE: outputs are held stable until an edge with rsp_ready == 1, which returns the FSM to IDLE. rsp_ready is ignored outside DONE.
REQ-023 cmd_ready is 0 in DONE even when rsp_ready is 1, so there is at least one IDLE cycle between commands.
REQ-024 cmd_valid is ignored while busy; the command is not queued.

Reset
REQ-025 Assertion of rst forces, asynchronously and regardless of state (including mid-MUL or in DONE):
  - state = IDLE;
  - rsp_data = 0, rsp_zero = 0, rsp_err = 0;
  - counter = 0, accumulator = 0;
  - rsp_valid = 0, busy = 0, cmd_ready = 1.
REQ-026 An in-flight operation is discarded and produces no response after reset releases.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: when defined, MUL (110) behaves per REQ-021. When undefined, the MUL state, counter and accumulator are not built, and 110 is treated as illegal per REQ-020.

Structure
REQ-028 Shared package alu_pkg holds BITS, the ALU opcode constants (ADD/SUB/AND/OR/SLT), the sequencer MUL code 110, and the FSM state type.
REQ-029 Exactly one sub-module, alu_8b, is instantiated for all arithmetic. No second adder is permitted for MUL.

Verification
REQ-030 Reset, then ADD a=8'hF0 b=8'h20 -> rsp_valid 1 edge after accept, rsp_data=8'h10, rsp_zero=0, rsp_err=0.
REQ-031 SUB a=8'h33 b=8'h33 -> rsp_data=8'h00, rsp_zero=1. Then SLT a=8'h01 b=8'hFF -> rsp_data=8'h01.
REQ-032 With ALU_SEQ_MUL_EN, MUL a=8'h0D b=8'h0B -> rsp_valid 8 edges after accept, rsp_data=8'h8F. MUL a=8'h10 b=8'h10 -> rsp_data=8'h00, rsp_zero=1.
REQ-033 Opcode 111 (and 110 without the macro) -> rsp_err=1, rsp_data=8'h00, rsp_zero=0, FSM returns to IDLE after rsp_ready.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable, and cmd_valid pulses meanwhile are ignored.
REQ-035 Assert rst at iteration 4 of MUL a=8'hFF b=8'hFF -> outputs zeroed immediately, and no response appears after release.
